led_morse_player: RTL and testbench

Plays ASCII characters on the board's user LED as Morse code and sits directly upstream of the LED pin, replacing the free-running counter bit as the `LED` source in `top`. An upstream character source, such as a message ROM walker, hands it one character at a time over a valid/ready handshake. The block times all dots, dashes and gaps from a single internal unit prescaler clocked by the 16 MHz board clock.

---
 rtl/led_morse_player.sv | 167 ++++++++++++++++
 tb/tb_led_morse_player.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_morse_player.sv
// led_morse_player: plays accepted ASCII characters on the LED as Morse code.
// All marks and gaps are whole multiples of one prescaled time unit.
module led_morse_player #(
    parameter int UNIT_CYCLES = 1600000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CHAR_VALID,
    input  logic [7:0] CHAR_DATA,
    output logic       CHAR_READY,
    output logic       LED,
    output logic       BUSY,
    output logic       BAD_CHAR
);

    localparam int UW = $clog2(UNIT_CYCLES);
    localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    state_t        state;
    logic [UW-1:0] ucnt;
    logic [2:0]    pcnt;
    logic [2:0]    plen;
    logic [2:0]    elem;
    logic [4:0]    pat;

    logic          tick;
    logic          phase_end;
    logic [7:0]    up;
    logic [2:0]    dec_n;
    logic [4:0]    dec_pat;
    logic          is_mark;
    logic          is_space;

    assign tick       = (ucnt == U_LAST);
    assign phase_end  = tick && (pcnt == plen - 3'd1);
    assign CHAR_READY = (state == IDLE);
    assign is_mark    = (dec_n != 3'd0);
    assign is_space   = (CHAR_DATA == 8'h20);

    // Case-fold and look up element count plus pattern (first element at bit 4, 1 = dash)
    always_comb begin
        up = CHAR_DATA;
        if (CHAR_DATA >= 8'h61 && CHAR_DATA <= 8'h7a)
            up = CHAR_DATA - 8'h20;
        dec_n   = 3'd0;
        dec_pat = 5'b00000;
        case (up)
            8'h41: {dec_n, dec_pat} = {3'd2, 5'b01000};
            8'h42: {dec_n, dec_pat} = {3'd4, 5'b10000};
            8'h43: {dec_n, dec_pat} = {3'd4, 5'b10100};
            8'h44: {dec_n, dec_pat} = {3'd3, 5'b10000};
            8'h45: {dec_n, dec_pat} = {3'd1, 5'b00000};
            8'h46: {dec_n, dec_pat} = {3'd4, 5'b00100};
            8'h47: {dec_n, dec_pat} = {3'd3, 5'b11000};
            8'h48: {dec_n, dec_pat} = {3'd4, 5'b00000};
            8'h49: {dec_n, dec_pat} = {3'd2, 5'b00000};
            8'h4a: {dec_n, dec_pat} = {3'd4, 5'b01110};
            8'h4b: {dec_n, dec_pat} = {3'd3, 5'b10100};
            8'h4c: {dec_n, dec_pat} = {3'd4, 5'b01000};
            8'h4d: {dec_n, dec_pat} = {3'd2, 5'b11000};
            8'h4e: {dec_n, dec_pat} = {3'd2, 5'b10000};
            8'h4f: {dec_n, dec_pat} = {3'd3, 5'b11100};
            8'h50: {dec_n, dec_pat} = {3'd4, 5'b01100};
            8'h51: {dec_n, dec_pat} = {3'd4, 5'b11010};
            8'h52: {dec_n, dec_pat} = {3'd3, 5'b01000};
            8'h53: {dec_n, dec_pat} = {3'd3, 5'b00000};
            8'h54: {dec_n, dec_pat} = {3'd1, 5'b10000};
            8'h55: {dec_n, dec_pat} = {3'd3, 5'b00100};
            8'h56: {dec_n, dec_pat} = {3'd4, 5'b00010};
            8'h57: {dec_n, dec_pat} = {3'd3, 5'b01100};
            8'h58: {dec_n, dec_pat} = {3'd4, 5'b10010};
            8'h59: {dec_n, dec_pat} = {3'd4, 5'b10110};
            8'h5a: {dec_n, dec_pat} = {3'd4, 5'b11000};
            8'h30: {dec_n, dec_pat} = {3'd5, 5'b11111};
            8'h31: {dec_n, dec_pat} = {3'd5, 5'b01111};
            8'h32: {dec_n, dec_pat} = {3'd5, 5'b00111};
            8'h33: {dec_n, dec_pat} = {3'd5, 5'b00011};
            8'h34: {dec_n, dec_pat} = {3'd5, 5'b00001};
            8'h35: {dec_n, dec_pat} = {3'd5, 5'b00000};
            8'h36: {dec_n, dec_pat} = {3'd5, 5'b10000};
            8'h37: {dec_n, dec_pat} = {3'd5, 5'b11000};
            8'h38: {dec_n, dec_pat} = {3'd5, 5'b11100};
            8'h39: {dec_n, dec_pat} = {3'd5, 5'b11110};
            default: ;
        endcase
    end

    // Player FSM with unit prescaler, per-phase unit count and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ucnt     <= '0;
            pcnt     <= 3'd0;
            plen     <= 3'd0;
            elem     <= 3'd0;
            pat      <= 5'b00000;
            LED      <= 1'b0;
            BUSY     <= 1'b0;
            BAD_CHAR <= 1'b0;
        end else begin
            BAD_CHAR <= 1'b0;
            if (state == IDLE) begin
                ucnt <= '0;
                pcnt <= 3'd0;
            end else begin
                ucnt <= tick ? '0 : ucnt + UW'(1);
                if (tick)
                    pcnt <= phase_end ? 3'd0 : pcnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    LED  <= 1'b0;
                    BUSY <= 1'b0;
                    if (CHAR_VALID) begin
                        unique case (1'b1)
                            is_mark: begin
                                state <= MARK;
                                LED   <= 1'b1;
                                BUSY  <= 1'b1;
                                elem  <= dec_n;
                                pat   <= dec_pat;
                                plen  <= dec_pat[4] ? 3'd3 : 3'd1;
                            end
                            is_space: begin
                                state <= GAP;
                                BUSY  <= 1'b1;
                                plen  <= 3'd7;
                            end
                            default: BAD_CHAR <= 1'b1;
                        endcase
                    end
                end
                MARK: begin
                    if (phase_end) begin
                        LED  <= 1'b0;
                        elem <= elem - 3'd1;
                        if (elem == 3'd1) begin
                            state <= GAP;
                            plen  <= 3'd3;
                        end else begin
                            state <= SPACE;
                            plen  <= 3'd1;
                            pat   <= {pat[3:0], 1'b0};
                        end
                    end
                end
                SPACE: begin
                    if (phase_end) begin
                        state <= MARK;
                        LED   <= 1'b1;
                        plen  <= pat[4] ? 3'd3 : 3'd1;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_morse_player.sv
// tb_led_morse_player: scoreboard bench for the Morse LED player.
// Expected LED runs and BUSY lengths are queued per character and popped by a monitor.
module tb_led_morse_player;

    localparam int U = 4;

    localparam int K_ON    = 0;
    localparam int K_OFF   = 1;
    localparam int K_BUSY  = 2;
    localparam int K_RDY   = 3;
    localparam int K_BSTAT = 4;
    localparam int K_BLEN  = 5;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CHAR_VALID = 1'b0;
    logic [7:0] CHAR_DATA = 8'h00;
    logic       CHAR_READY;
    logic       LED;
    logic       BUSY;
    logic       BAD_CHAR;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    led_morse_player #(.UNIT_CYCLES(U)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CHAR_VALID(CHAR_VALID),
        .CHAR_DATA (CHAR_DATA),
        .CHAR_READY(CHAR_READY),
        .LED       (LED),
        .BUSY      (BUSY),
        .BAD_CHAR  (BAD_CHAR)
    );

    always #5 CLK = ~CLK;

    function automatic string kname(int k);
        case (k)
            K_ON:    return "led_on_run";
            K_OFF:   return "led_off_run";
            K_BUSY:  return "busy_len";
            K_RDY:   return "ready_after_busy";
            K_BSTAT: return "bad_status";
            K_BLEN:  return "bad_len";
            default: return "unknown";
        endcase
    endfunction

    function automatic void check(string nm, int got, int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endfunction

    function automatic void push(int kind, int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endfunction

    function automatic void pop(int kind, int val);
        exp_t e;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL %s: got %0d, nothing expected", kname(kind), val);
            return;
        end
        e = q.pop_front();
        if (e.kind == kind && e.val == val) n_pass++;
        else $display("FAIL %s: got %s=%0d want %s=%0d",
                      kname(e.kind), kname(kind), val, kname(e.kind), e.val);
    endfunction

    // Expected runs for a hand-written dot/dash string, plus busy length and ready
    task automatic push_morse(input string p);
        int tot;
        int l;
        tot = 0;
        for (int i = 0; i < p.len(); i++) begin
            l = (p[i] == "-") ? 3 * U : U;
            push(K_ON, l);
            tot += l;
            if (i == p.len() - 1) begin
                push(K_OFF, 3 * U);
                tot += 3 * U;
            end else begin
                push(K_OFF, U);
                tot += U;
            end
        end
        push(K_BUSY, tot);
        push(K_RDY, 1);
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge CLK);
        while (!CHAR_READY && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (!CHAR_READY) begin
            n_chk++;
            $display("FAIL ready_timeout: got ready=0 want 1 for char %h", c);
        end
        CHAR_DATA  = c;
        CHAR_VALID = 1'b1;
        @(posedge CLK);
        #1 CHAR_VALID = 1'b0;
    endtask

    // Monitor: splits LED into runs while BUSY, checks busy length and BAD_CHAR pulses
    initial begin
        int blen;
        int rlen;
        int rlvl;
        int bcnt;
        blen = 0;
        rlen = 0;
        rlvl = 0;
        bcnt = 0;
        forever begin
            @(negedge CLK);
            if (BUSY) begin
                if (rlen > 0 && int'(LED) != rlvl) begin
                    pop(rlvl != 0 ? K_ON : K_OFF, rlen);
                    rlen = 0;
                end
                if (rlen == 0) rlvl = int'(LED);
                rlen++;
                blen++;
            end else if (blen > 0) begin
                pop(rlvl != 0 ? K_ON : K_OFF, rlen);
                pop(K_BUSY, blen);
                pop(K_RDY, int'(CHAR_READY));
                blen = 0;
                rlen = 0;
            end else if (LED) begin
                n_chk++;
                $display("FAIL led_idle: got LED=1 want 0 while not busy");
            end
            if (BAD_CHAR) begin
                if (bcnt == 0) pop(K_BSTAT, int'({CHAR_READY, LED, BUSY}));
                bcnt++;
            end else if (bcnt > 0) begin
                pop(K_BLEN, bcnt);
                bcnt = 0;
            end
        end
    end

    initial begin
        int n;
        #1;
        check("rst_ready", int'(CHAR_READY), 1);
        check("rst_led", int'(LED), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_bad", int'(BAD_CHAR), 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(negedge CLK);
        check("idle_ready", int'(CHAR_READY), 1);
        check("idle_led", int'(LED), 0);

        push_morse(".");     send(8'h45);
        push_morse(".-");    send(8'h61);
        push_morse(".-");    send(8'h41);
        push_morse("-----"); send(8'h30);
        push_morse("--..."); send(8'h37);
        push_morse("--..");  send(8'h7a);

        push(K_OFF, 7 * U);
        push(K_BUSY, 7 * U);
        push(K_RDY, 1);
        send(8'h20);

        push(K_BSTAT, 4);
        push(K_BLEN, 1);
        send(8'h23);

        push_morse("...");   send(8'h53);
        push_morse("---");   send(8'h4f);
        push_morse("...");   send(8'h53);

        push(K_ON, 5);
        push(K_BUSY, 5);
        push(K_RDY, 1);
        send(8'h54);
        repeat (5) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_led", int'(LED), 0);
        check("async_busy", int'(BUSY), 0);
        check("async_ready", int'(CHAR_READY), 1);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;

        push_morse(".");     send(8'h45);

        n = 0;
        while ((q.size() != 0 || BUSY) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d items left want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
